// File: rtl/dma_arbiter.sv
// 2A03 CPU-bus arbiter: shares the bus between the 6502 core,
// OAM sprite DMA and DMC sample fetches, stalling the core via ready.
module dma_arbiter #(
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter logic [15:0] OAM_TRIG_ADDR = 16'h4014
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_cycle,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  input  logic        I_dmc_req,
  input  logic [15:0] I_dmc_addr,
  output logic        O_cpu_ready,
  output logic        O_dma_active,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_dmc_ack,
  output logic [7:0]  O_dmc_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HALT      = 3'd1;
  localparam logic [2:0] S_ALIGN     = 3'd2;
  localparam logic [2:0] S_OAM_RD    = 3'd3;
  localparam logic [2:0] S_OAM_WR    = 3'd4;
  localparam logic [2:0] S_DMC_DUMMY = 3'd5;
  localparam logic [2:0] S_DMC_RD    = 3'd6;
  localparam logic [2:0] S_REALIGN   = 3'd7;

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  logic        parity;
  logic        oam_mode;
  logic        nxt_oam;
  logic [7:0]  page;
  logic [7:0]  nxt_page;
  logic [7:0]  index;
  logic [7:0]  nxt_index;
  logic [15:0] nxt_addr;
  logic        next_get;
  logic        oam_trig;
  logic [2:0]  oam_get;

  // parity is that of the cycle in progress; the next one flips it
  assign next_get = parity;

  assign oam_trig = !I_cpu_rdwr
                 && (I_cpu_addr == OAM_TRIG_ADDR);

  // a pending DMC fetch steals any OAM get slot
  assign oam_get = I_dmc_req ? S_DMC_RD : S_OAM_RD;

  always_comb begin
    nxt_state = state;
    nxt_oam   = oam_mode;
    nxt_page  = page;
    nxt_index = index;
    unique case (state)
      S_IDLE: begin
        if (oam_trig) begin
          nxt_state = S_HALT;
          nxt_oam   = 1'b1;
          nxt_page  = I_cpu_wr_data;
          nxt_index = 8'h00;
        end else if (I_dmc_req) begin
          nxt_state = S_HALT;
          nxt_oam   = 1'b0;
        end
      end
      S_HALT: begin
        if (!oam_mode)
          nxt_state = S_DMC_DUMMY;
        else if (next_get)
          nxt_state = oam_get;
        else
          nxt_state = S_ALIGN;
      end
      S_ALIGN: begin
        nxt_state = oam_mode ? oam_get : S_DMC_RD;
      end
      S_DMC_DUMMY: begin
        nxt_state = next_get ? S_DMC_RD : S_ALIGN;
      end
      S_OAM_RD: begin
        nxt_state = S_OAM_WR;
      end
      S_OAM_WR: begin
        nxt_index = index + 8'd1;
        if (index == 8'hFF) begin
          nxt_state = S_IDLE;
          nxt_oam   = 1'b0;
        end else begin
          nxt_state = oam_get;
        end
      end
      S_DMC_RD: begin
        nxt_state = oam_mode ? S_REALIGN : S_IDLE;
      end
      S_REALIGN: begin
        nxt_state = oam_get;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_oam   = 1'b0;
      end
    endcase
  end

  always_comb begin
    nxt_addr = 16'h0000;
    unique case (nxt_state)
      S_IDLE:
        nxt_addr = 16'h0000;
      S_HALT, S_ALIGN:
        nxt_addr = nxt_oam ? {nxt_page, 8'h00}
                           : I_dmc_addr;
      S_OAM_RD, S_REALIGN:
        nxt_addr = {nxt_page, nxt_index};
      S_OAM_WR:
        nxt_addr = OAM_DATA_ADDR;
      S_DMC_DUMMY, S_DMC_RD:
        nxt_addr = I_dmc_addr;
      default:
        nxt_addr = 16'h0000;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state        <= S_IDLE;
      parity       <= 1'b0;
      oam_mode     <= 1'b0;
      page         <= 8'h00;
      index        <= 8'h00;
      O_cpu_ready  <= 1'b1;
      O_dma_active <= 1'b0;
      O_addr       <= 16'h0000;
      O_wr_data    <= 8'h00;
      O_rdwr       <= 1'b1;
      O_dmc_ack    <= 1'b0;
      O_dmc_data   <= 8'h00;
    end else begin
      O_dmc_ack <= 1'b0;
      if (I_cycle) begin
        state        <= nxt_state;
        parity       <= ~parity;
        oam_mode     <= nxt_oam;
        page         <= nxt_page;
        index        <= nxt_index;
        O_cpu_ready  <= (nxt_state == S_IDLE);
        O_dma_active <= (nxt_state != S_IDLE);
        O_addr       <= nxt_addr;
        O_rdwr       <= (nxt_state != S_OAM_WR);
        if (state == S_OAM_RD)
          O_wr_data <= I_rd_data;
        if (state == S_DMC_RD) begin
          O_dmc_ack  <= 1'b1;
          O_dmc_data <= I_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: OAM/DMC sequencing, stall
// lengths, mid-transfer reset and strobe-gap behaviour.
module tb_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wd;
  logic        cpu_rdwr;
  logic [7:0]  rd_data;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        ready;
  logic        active;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        rdwr;
  logic        ack;
  logic [7:0]  dmc_data;

  int checks = 0;
  int errors = 0;
  bit bp;

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  wd;
    bit          any_addr;
    bit          is_dmc;
  } ent_t;

  ent_t exp_q[$];

  always #5 clk = ~clk;

  dma_arbiter dut (
    .I_clock      (clk),
    .I_reset      (rst_n),
    .I_cycle      (cyc),
    .I_cpu_addr   (cpu_addr),
    .I_cpu_wr_data(cpu_wd),
    .I_cpu_rdwr   (cpu_rdwr),
    .I_rd_data    (rd_data),
    .I_dmc_req    (dmc_req),
    .I_dmc_addr   (dmc_addr),
    .O_cpu_ready  (ready),
    .O_dma_active (active),
    .O_addr       (addr),
    .O_wr_data    (wr_data),
    .O_rdwr       (rdwr),
    .O_dmc_ack    (ack),
    .O_dmc_data   (dmc_data)
  );

  function automatic logic [7:0] bus_byte(input logic [15:0] a);
    if (a == 16'hC123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign rd_data = bus_byte(addr);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc = 1'b1;
    @(negedge clk);
    cyc = 1'b0;
    bp = ~bp;
  endtask

  task automatic trig(input logic [7:0] pg);
    cpu_addr = 16'h4014;
    cpu_rdwr = 1'b0;
    cpu_wd   = pg;
    step();
    cpu_addr = 16'h0000;
    cpu_rdwr = 1'b1;
    cpu_wd   = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wr_data, 0);
    chk({tag, "_rdwr"}, rdwr, 1);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_dmcdata"}, dmc_data, 0);
  endtask

  task automatic oam_run(input logic [7:0] pg,
                         input bit on_get,
                         input int dmc_idx,
                         input int hold_pos,
                         input int exp_stall);
    int   n;
    int   base;
    ent_t cur;
    exp_q.delete();
    exp_q.push_back(ent_t'{addr:{pg, 8'h00}, rdwr:1'b1,
                    wd:8'h00, any_addr:0, is_dmc:0});
    if (!on_get)
      exp_q.push_back(ent_t'{addr:{pg, 8'h00}, rdwr:1'b1,
                      wd:8'h00, any_addr:0, is_dmc:0});
    for (int i = 0; i < 256; i++) begin
      if (i == dmc_idx) begin
        exp_q.push_back(ent_t'{addr:16'hC123, rdwr:1'b1,
                        wd:8'h00, any_addr:0, is_dmc:1});
        exp_q.push_back(ent_t'{addr:16'h0000, rdwr:1'b1,
                        wd:8'h00, any_addr:1, is_dmc:0});
      end
      exp_q.push_back(ent_t'{addr:{pg, i[7:0]}, rdwr:1'b1,
                      wd:8'h00, any_addr:0, is_dmc:0});
      exp_q.push_back(ent_t'{addr:16'h2004, rdwr:1'b0,
                      wd:bus_byte({pg, i[7:0]}),
                      any_addr:0, is_dmc:0});
    end
    base = on_get ? 1 : 2;
    if (bp != !on_get) step();
    trig(pg);
    n = 0;
    while (!ready && n < 700) begin
      if (n >= exp_q.size()) begin
        chk("oam_overrun", n, exp_q.size());
        break;
      end
      cur = exp_q[n];
      chk("oam_active", active, 1);
      if (!cur.any_addr) chk("oam_addr", addr, cur.addr);
      chk("oam_rdwr", rdwr, cur.rdwr);
      if (!cur.rdwr) chk("oam_wdata", wr_data, cur.wd);
      if (dmc_idx > 0 && n == base + 2 * (dmc_idx - 1) + 1) begin
        dmc_req  = 1'b1;
        dmc_addr = 16'hC123;
      end
      if (n == hold_pos) begin
        dmc_req = 1'b1;
        repeat (20) @(negedge clk);
        dmc_req = 1'b0;
        chk("hold_addr", addr, cur.addr);
        chk("hold_rdwr", rdwr, 1);
        chk("hold_ready", ready, 0);
        chk("hold_wdata", wr_data, exp_q[n-1].wd);
      end
      step();
      n++;
      if (cur.is_dmc) begin
        chk("oam_dmc_ack", ack, 1);
        chk("oam_dmc_data", dmc_data, 8'h5A);
        dmc_req = 1'b0;
        @(negedge clk);
        chk("oam_ack_clear", ack, 0);
      end
    end
    chk("oam_stall", n, exp_stall);
    chk("oam_end_ready", ready, 1);
    chk("oam_end_active", active, 0);
  endtask

  task automatic dmc_idle(input bit on_get, input int exp_stall);
    int n;
    if (bp != !on_get) step();
    dmc_req  = 1'b1;
    dmc_addr = 16'hC123;
    step();
    n = 0;
    while (!ready && n < 20) begin
      chk("dmc_active", active, 1);
      chk("dmc_addr", addr, 16'hC123);
      chk("dmc_rdwr", rdwr, 1);
      step();
      n++;
    end
    chk("dmc_ack", ack, 1);
    chk("dmc_data", dmc_data, 8'h5A);
    dmc_req = 1'b0;
    @(negedge clk);
    chk("dmc_ack_clear", ack, 0);
    chk("dmc_stall", n, exp_stall);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    cyc      = 1'b0;
    cpu_addr = 16'h0000;
    cpu_wd   = 8'h00;
    cpu_rdwr = 1'b1;
    dmc_req  = 1'b0;
    dmc_addr = 16'h0000;
    bp       = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    oam_run(8'h02, 1'b1, -1, -1, 513);
    oam_run(8'h02, 1'b0, -1, -1, 514);

    dmc_idle(1'b1, 4);
    dmc_idle(1'b0, 3);

    oam_run(8'h02, 1'b1, 'h40, -1, 515);

    if (bp) step();
    trig(8'h03);
    repeat (201) step();
    chk("mid_addr", addr, 16'h0364);
    chk("mid_ready", ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bp    = 1'b0;
    oam_run(8'h04, 1'b1, -1, -1, 513);

    oam_run(8'h05, 1'b1, -1, 21, 513);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
